// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the round-robin memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshake and memory strobe bundle for mem_arbiter.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   busy;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_data_in;
    logic                   mem_read;
    logic                   mem_write;
    logic [DATA_W-1:0]      mem_data_out;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata, busy,
               mem_addr, mem_data_in, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata, busy,
               mem_addr, mem_data_in, mem_read, mem_write
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    always_comb begin
        logic [IDW-1:0] idx;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDW'((int'(ptr) + i) % N);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory among NREQ requesters, one access per two cycles,
// with round-robin fairness and a one-cycle response pulse per completed command.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    cmd_t              cmd_q, cmd_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_id;
    logic              gnt_any;
    cmd_t              sel_cmd;

    rr_arbiter #(.N(NREQ), .IDW(IDW)) u_rr (
        .req    (bus.req_valid),
        .ptr    (rr_ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

    always_comb begin
        sel_cmd.write = bus.req_write[gnt_id];
        sel_cmd.addr  = bus.req_addr[gnt_id*ADDR_W +: ADDR_W];
        sel_cmd.wdata = bus.req_wdata[gnt_id*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        cmd_d       = cmd_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d     = ACCESS;
                    grant_id_d  = gnt_id;
                    cmd_d       = sel_cmd;
                    mem_read_d  = ~sel_cmd.write;
                    mem_write_d = sel_cmd.write;
                end
            end
            ACCESS: begin
                // Memory read data is only valid while the read strobe is up, so capture it now.
                state_d                 = IDLE;
                rsp_valid_d[grant_id_q] = 1'b1;
                rsp_rdata_d             = cmd_q.write ? '0 : bus.mem_data_out;
                rr_ptr_d                = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            cmd_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            cmd_q       <= cmd_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Ready is masked while reset is held so no requester sees a phantom accept.
    assign bus.req_ready   = (state_q == IDLE && rst_n) ? gnt : '0;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.busy        = (state_q == ACCESS);
    assign bus.mem_addr    = cmd_q.addr;
    assign bus.mem_data_in = cmd_q.wdata;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: accepted commands are queued, a negedge monitor
// compares grants, strobes and responses against a queue/array reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 8;

    typedef struct {
        int             id;
        bit             w;
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;
        int             cyc;
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory slave: combinational read, write on the rising edge.
    logic [DW-1:0] tb_mem [32] = '{default: '0};
    always @(posedge clk) if (bus.mem_write) tb_mem[bus.mem_addr] <= bus.mem_data_in;
    assign bus.mem_data_out = tb_mem[bus.mem_addr];

    // Reference model state
    logic [DW-1:0]   ref_mem [32] = '{default: '0};
    txn_t            exp_q [$];
    txn_t            cur;
    int              mptr       = 0;
    int              strobe_cyc = -10;
    logic [NREQ-1:0] accepted   = '0;
    int              grant_log [$];
    logic [DW-1:0]   rsp_log [$];
    int              rsp_cnt [NREQ];
    int              ready_cnt [NREQ];
    int              strobe_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] grant_at(int i);
        if (i < grant_log.size()) return 32'(grant_log[i]);
        return 'x;
    endfunction

    function automatic logic [31:0] rsp_at(int i);
        if (i < rsp_log.size()) return 32'(rsp_log[i]);
        return 'x;
    endfunction

    task automatic monitor_cycle();
        logic [NREQ-1:0] exp_rdy;
        bit              bexp;
        txn_t            e;
        logic [DW-1:0]   ed;
        int              g;
        bexp = (cyc == strobe_cyc);
        for (int i = 0; i < NREQ; i++) begin
            if (bus.rsp_valid[i]) rsp_cnt[i]++;
            if (bus.req_ready[i]) ready_cnt[i]++;
        end
        if (bus.mem_read || bus.mem_write) strobe_cnt++;
        chk("busy", 32'(bus.busy), 32'(bexp));
        if (bexp) begin
            chk("mem_write", 32'(bus.mem_write), 32'(cur.w));
            chk("mem_read", 32'(bus.mem_read), 32'(!cur.w));
            chk("mem_addr", 32'(bus.mem_addr), 32'(cur.a));
            if (cur.w) chk("mem_data_in", 32'(bus.mem_data_in), 32'(cur.d));
        end else begin
            chk("idle_strobes", 32'({bus.mem_read, bus.mem_write}), 32'(0));
        end
        if (exp_q.size() > 0 && exp_q[0].cyc + 2 == cyc) begin
            e  = exp_q.pop_front();
            ed = e.w ? '0 : ref_mem[e.a];
            if (e.w) ref_mem[e.a] = e.d;
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(NREQ'(1) << e.id));
            chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(ed));
            rsp_log.push_back(bus.rsp_rdata);
        end else begin
            chk("rsp_quiet", 32'(bus.rsp_valid), 32'(0));
        end
        exp_rdy = '0;
        g       = -1;
        if (!bexp) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (mptr + k) % NREQ;
                if (g < 0 && bus.req_valid[idx]) begin
                    g            = idx;
                    exp_rdy[idx] = 1'b1;
                end
            end
        end
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (g >= 0) begin
            cur = '{g, bus.req_write[g], bus.req_addr[g*AW +: AW], bus.req_wdata[g*DW +: DW], cyc};
            exp_q.push_back(cur);
            accepted[g] = 1'b1;
            strobe_cyc  = cyc + 1;
            mptr        = (g + 1) % NREQ;
            grant_log.push_back(g);
        end
    endtask

    always @(negedge clk) if (rst_n) monitor_cycle();

    task automatic set_cmd(input int id, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[id]       = 1'b1;
        bus.req_write[id]       = w;
        bus.req_addr[id*AW +: AW] = a;
        bus.req_wdata[id*DW +: DW] = d;
    endtask

    // Drops each requester's valid right after its accept; bounded wait.
    task automatic wait_done(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] pend;
        int              n;
        pend = mask;
        n    = 0;
        while (pend != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && accepted[i]) begin
                    accepted[i]      = 1'b0;
                    bus.req_valid[i] = 1'b0;
                    pend[i]          = 1'b0;
                end
            end
        end
        if (pend != 0) begin
            chk("accept_timeout", 32'(pend), 32'(0));
            bus.req_valid = bus.req_valid & ~pend;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic flush_model();
        exp_q.delete();
        strobe_cyc = -10;
        mptr       = 0;
        accepted   = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'(0));
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
        chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'(0));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
        chk({tag, "_strobes"}, 32'({bus.mem_read, bus.mem_write}), 32'(0));
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(0));
        chk({tag, "_mem_data_in"}, 32'(bus.mem_data_in), 32'(0));
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        flush_model();
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic random_phase(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (accepted[i]) begin
                    accepted[i]      = 1'b0;
                    bus.req_valid[i] = 1'b0;
                end
                if (!bus.req_valid[i] && $urandom_range(2) == 0)
                    set_cmd(i, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom_range(255)));
                else if (bus.req_valid[i] && $urandom_range(15) == 0)
                    bus.req_valid[i] = 1'b0;
            end
        end
        bus.req_valid = '0;
        accepted      = '0;
    endtask

    initial begin
        logic [DW-1:0] prev7;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_cnt[i]   = 0;
            ready_cnt[i] = 0;
        end
        #1;
        check_reset_outputs("init");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back through requester 0
        rsp_log.delete();
        set_cmd(0, 1'b1, 5'h03, 8'hA5);
        wait_done(4'b0001);
        set_cmd(0, 1'b0, 5'h03, 8'h00);
        wait_done(4'b0001);
        drain();
        chk("t1_write_rsp", rsp_at(0), 32'h00);
        chk("t1_read_rsp", rsp_at(1), 32'hA5);

        // All requesters at once, then readback
        do_reset();
        grant_log.delete();
        rsp_log.delete();
        for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b1, AW'(i), DW'(8'h10 + i));
        wait_done(4'b1111);
        drain();
        for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, AW'(i), 8'h00);
        wait_done(4'b1111);
        drain();
        for (int i = 0; i < NREQ; i++) begin
            chk("t2_grant_order", grant_at(i), 32'(i));
            chk("t2_readback", rsp_at(NREQ + i), 32'(8'h10 + i));
        end

        // Pointer at 2 with only 1 and 3 requesting
        do_reset();
        set_cmd(1, 1'b0, 5'h00, 8'h00);
        wait_done(4'b0010);
        drain();
        grant_log.delete();
        set_cmd(1, 1'b0, 5'h01, 8'h00);
        set_cmd(3, 1'b0, 5'h02, 8'h00);
        wait_done(4'b1010);
        drain();
        set_cmd(0, 1'b0, 5'h00, 8'h00);
        set_cmd(3, 1'b0, 5'h03, 8'h00);
        wait_done(4'b1001);
        drain();
        chk("t3_first", grant_at(0), 32'd3);
        chk("t3_second", grant_at(1), 32'd1);
        chk("t3_ptr_end", grant_at(2), 32'd3);

        // Boundary addresses
        rsp_log.delete();
        set_cmd(2, 1'b1, 5'h1F, 8'hFF);
        wait_done(4'b0100);
        set_cmd(2, 1'b1, 5'h00, 8'h00);
        wait_done(4'b0100);
        set_cmd(2, 1'b0, 5'h1F, 8'h00);
        wait_done(4'b0100);
        set_cmd(2, 1'b0, 5'h00, 8'h00);
        wait_done(4'b0100);
        drain();
        chk("t4_read_1f", rsp_at(2), 32'hFF);
        chk("t4_read_00", rsp_at(3), 32'h00);

        // Reset during the access cycle of a write
        do_reset();
        prev7 = tb_mem[7];
        set_cmd(0, 1'b1, 5'h07, 8'h5A);
        wait_done(4'b0001);
        chk("t5_write_up", 32'(bus.mem_write), 32'd1);
        #1 rst_n = 1'b0;
        flush_model();
        #1;
        check_reset_outputs("t5");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("t5_no_rsp", 32'(bus.rsp_valid), 32'(0));
        end
        #2 rst_n = 1'b1;
        chk("t5_write_lost", 32'(tb_mem[7]), 32'(prev7));
        @(posedge clk);
        #1;
        grant_log.delete();
        set_cmd(2, 1'b0, 5'h07, 8'h00);
        set_cmd(1, 1'b0, 5'h07, 8'h00);
        wait_done(4'b0110);
        drain();
        chk("t5_lowest_first", grant_at(0), 32'd1);

        // Requester 2 pulses valid only while requester 0 is being served
        for (int i = 0; i < NREQ; i++) begin
            rsp_cnt[i]   = 0;
            ready_cnt[i] = 0;
        end
        strobe_cnt = 0;
        set_cmd(0, 1'b1, 5'h09, 8'h66);
        wait_done(4'b0001);
        set_cmd(2, 1'b1, 5'h0A, 8'h77);
        #2 bus.req_valid[2] = 1'b0;
        repeat (5) @(posedge clk);
        drain();
        chk("t6_no_ready2", 32'(ready_cnt[2]), 32'(0));
        chk("t6_no_rsp2", 32'(rsp_cnt[2]), 32'(0));
        chk("t6_rsp0", 32'(rsp_cnt[0]), 32'(1));
        chk("t6_one_strobe", 32'(strobe_cnt), 32'(1));

        // Randomised traffic against the reference model
        random_phase(400);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Round-robin arbiter/sequencer that shares one 32x8 single-port memory between NREQ independent requesters. Each requester issues single-beat read or write commands over a valid/ready handshake. The block serialises them onto the memory strobes (addr, data_in, read, write) and returns a per-requester response pulse with read data. It sits between the testbench/agent layer and the memory slave, in place of direct task-driven access.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDR_W, 5, memory address width (32 locations)
DATA_W, 8, memory data width

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  NREQ  per-requester command valid
req_write  input  NREQ  1 = write, 0 = read, per requester
req_addr  input  NREQ*ADDR_W  packed per-requester address, requester i at bits [i*ADDR_W +: ADDR_W]
req_wdata  input  NREQ*DATA_W  packed per-requester write data
req_ready  output  NREQ  command accepted this cycle (at most one bit set)
rsp_valid  output  NREQ  one-cycle completion pulse to the granted requester
rsp_rdata  output  DATA_W  read data, shared; qualified by rsp_valid
busy  output  1  high while state is ACCESS
mem_addr  output  ADDR_W  to memory addr
mem_data_in  output  DATA_W  to memory data_in
mem_read  output  1  to memory read strobe
mem_write  output  1  to memory write strobe
mem_data_out  input  DATA_W  from memory data_out; valid in the same cycle mem_read is high

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, mem_read=0, mem_write=0, mem_addr=0, mem_data_in=0.
- FSM has 2 states: IDLE, ACCESS.
- IDLE, cycle T: arbitration is combinational over req_valid, scanning from rr_ptr upward modulo NREQ. The first valid requester w gets req_ready[w]=1. On the rising edge, latch its write/addr/wdata into registered mem_* outputs, set grant_id=w, and go to ACCESS. With no valid requests, stay in IDLE.
- ACCESS, cycle T+1: mem_read=~cmd_write and mem_write=cmd_write, each high for exactly this one cycle. busy=1 and req_ready=0. On the rising edge: capture rsp_rdata=mem_data_out for reads (0 for writes), set rsp_valid[w] for the next cycle, set rr_ptr=(w+1) mod NREQ, and return to IDLE.
- T+2: rsp_valid[w]=1 for exactly one cycle. IDLE arbitration runs in the same cycle, so sustained throughput is one access per 2 cycles and request-to-response latency is 2 cycles.
- Handshake: the requester holds addr/wdata/write stable while valid && !ready. Dropping valid before ready is permitted; no command is issued in that case. A requester may re-request in the cycle its rsp_valid is high.
- mem_addr and mem_data_in hold their last values in IDLE. mem_read and mem_write are never high simultaneously and are never high in IDLE.
- Fairness: with all requesters continuously valid, the grant order is 0,1,..,NREQ-1,0. No requester waits more than NREQ grants.
- rr_ptr wraps from NREQ-1 to 0. The pointer advances only on a grant.
- Reset mid-ACCESS: strobes drop immediately (async), the in-flight write may be lost, and no rsp_valid is produced.
- Address and data are passed through unmodified. No range checks are needed because ADDR_W covers the whole memory.

Decomposition:
- Package mem_arb_pkg holds: ADDR_W and DATA_W defaults, state_t enum {IDLE, ACCESS}, and cmd_t struct {write, addr, wdata}.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs one-hot gnt[N], gnt_id and any. It is purely combinational. The pointer register stays in mem_arbiter.

Test Plan:
1. Requester 0 writes addr 5'h03 data 8'hA5, then reads 5'h03 -> one mem_write pulse with mem_addr=03, mem_data_in=A5; then a read with rsp_valid[0] 2 cycles after acceptance and rsp_rdata=A5.
2. All 4 requesters valid at once, each writing addr=i, data=8'h10+i, held continuously -> grants in order 0,1,2,3, one every 2 cycles; a readback of addr 0..3 returns 10,11,12,13.
3. Only requesters 1 and 3 valid with rr_ptr=2 -> requester 3 is granted first, then 1; rr_ptr ends at 2.
4. Boundary addresses: write 5'h1F=8'hFF and 5'h00=8'h00, then read both -> FF and 00 returned with no aliasing.
5. rst_n asserted during the ACCESS cycle of a write to 5'h07 -> mem_write drops asynchronously, no rsp_valid, all outputs at reset values; after release, the next request is granted to the lowest valid index.
6. req_valid[2] raised then dropped while requester 0 is being served -> requester 2 never receives req_ready or rsp_valid, and no extra memory strobe occurs.
